// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
//
// Memory-mapped 8N1 UART transmitter for the riscv_soc peripheral slot on
// simple_bus. The CPU stores bytes into a small TX FIFO, and a baud-timed
// serializer drains it. Each byte goes out as a frame: one start bit, eight
// data bits LSB first, one stop bit. The line idles high.
//
// Register map (uart_addr[1:0] ignored):
//   0x0 TXDATA : write pushes wdata[7:0]; read returns 0
//   0x4 STATUS : read {28'b0, overflow, empty, full, busy};
//                write with wdata[3]=1 clears the sticky overflow flag
//   0x8, 0xC   : read 0, writes ignored
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   uart_req   single-cycle bus access strobe
//   uart_we    1 = write, 0 = read
//   uart_addr  byte offset within the block
//   uart_wdata write data
//   uart_rdata registered read data, held until the next read
//   uart_ready registered one-cycle access acknowledge
//   uart_tx    registered serial output, idle high

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_req,
  input  logic        uart_we,
  input  logic [3:0]  uart_addr,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic        wr_txdata, wr_status, rd_access;
  logic        fifo_full, fifo_empty, busy;
  logic        push, pop;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{uart_addr[1:0], uart_wdata[31:8]};

  // Bus decode and FIFO flags. Full is taken from the pre-edge count, so a
  // pop on the same edge never makes room for a push to a full FIFO.
  always_comb begin
    wr_txdata  = uart_req & uart_we & (uart_addr[3:2] == 2'd0);
    wr_status  = uart_req & uart_we & (uart_addr[3:2] == 2'd1);
    rd_access  = uart_req & ~uart_we;
    fifo_full  = (count_q == CNT_FULL);
    fifo_empty = (count_q == '0);
    busy       = (state_q != IDLE);
    push       = wr_txdata & ~fifo_full;
    status     = {28'd0, overflow_q, fifo_empty, fifo_full, busy};
  end

  // Serializer next state. The line level is derived from the next state so
  // that uart_tx comes straight from a flop and changes on the same edge as
  // the state it belongs to.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = mem_q[rd_ptr_q];
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (wr_txdata && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wr_status && uart_wdata[3]) begin
      overflow_d = 1'b0;
    end
  end

  // Bus response: every access is acknowledged one cycle later; read data is
  // only updated by reads so it holds across writes.
  always_comb begin
    ready_d = uart_req;
    rdata_d = rdata_q;
    if (rd_access) begin
      rdata_d = (uart_addr[3:2] == 2'd1) ? status : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= uart_wdata[7:0];
    end
  end

  assign uart_tx    = tx_q;
  assign uart_ready = ready_q;
  assign uart_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Testbench for uart_tx_fifo with a short bit time and the default FIFO depth.
// A line receiver decodes frames from uart_tx; a queue-based model predicts
// which pushes are accepted, when each frame starts, and the STATUS word.

module tb_uart_tx_fifo;

  localparam int C = 16;
  localparam int D = 8;
  localparam int F = 10 * C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uart_req = 1'b0;
  logic        uart_we = 1'b0;
  logic [3:0]  uart_addr = 4'd0;
  logic [31:0] uart_wdata = 32'd0;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .uart_req(uart_req), .uart_we(uart_we),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
    .uart_ready(uart_ready), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number n, cyc reads n.
  always @(posedge clk) cyc++;

  // Line receiver: detects the falling start edge, samples mid-bit.
  bit         mon_active = 1'b0;
  int         mon_cnt, mon_start, mon_k;
  bit         mon_err;
  logic [7:0] mon_byte;
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  bit         rx_err_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_start = cyc;
        mon_err = 1'b0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == C / 2) begin
        mon_k = mon_cnt / C;
        if (mon_k == 0) begin
          if (uart_tx !== 1'b0) mon_err = 1'b1;
        end else if (mon_k <= 8) begin
          mon_byte[mon_k-1] = uart_tx;
        end else begin
          if (uart_tx !== 1'b1) mon_err = 1'b1;
          rx_q.push_back(mon_byte);
          rx_start_q.push_back(mon_start);
          rx_err_q.push_back(mon_err);
          mon_active = 1'b0;
        end
      end
    end
  end

  // Reference model: accepted pushes and their frame start edges.
  int acc_q[$];
  int start_q[$];
  bit m_ovf;

  function automatic int occ_at(input int t);
    int n = 0;
    foreach (acc_q[k]) if (acc_q[k] < t) n++;
    foreach (start_q[k]) if (start_q[k] < t) n--;
    return n;
  endfunction

  function automatic bit model_push(input int t);
    int s;
    if (occ_at(t) >= D) begin
      m_ovf = 1'b1;
      return 1'b0;
    end
    s = t + 1;
    if (start_q.size() > 0 && start_q[start_q.size()-1] + F > s)
      s = start_q[start_q.size()-1] + F;
    acc_q.push_back(t);
    start_q.push_back(s);
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status(input int t);
    int o = occ_at(t);
    bit b = 1'b0;
    foreach (start_q[k]) if (start_q[k] <= t - 1 && t - 1 < start_q[k] + F) b = 1'b1;
    return {28'd0, m_ovf, (o == 0), (o == D), b};
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    acc_q.delete();
    start_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_start_q.delete();
    rx_err_q.delete();
  endtask

  // One bus access; called and returns at 1ns after a rising edge.
  task automatic bus_access(input bit we, input logic [3:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic rdy, output int t);
    uart_req = 1'b1;
    uart_we = we;
    uart_addr = addr;
    uart_wdata = wd;
    @(posedge clk); #1;
    t = cyc;
    rd = uart_rdata;
    rdy = uart_ready;
    uart_req = 1'b0;
    uart_we = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_tx: got %b want 1", uart_tx); end
    n_cmp++; if (uart_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 0", uart_ready); end
    n_cmp++; if (uart_rdata !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_rdata: got %h want 0", uart_rdata); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rx_clear();
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_tx: got %b want 1", uart_tx); end
  endtask

  task automatic test_status_idle();
    logic [31:0] rd, prev;
    logic rdy;
    int t;
    logic [3:0] a;
    bus_access(1'b0, {2'b01, 2'($urandom)}, $urandom, rd, rdy, t);
    prev = model_status(t);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL status_ready: got %b want 1", rdy); end
    n_cmp++; if (rd !== prev) begin n_bad++; $display("[TB] FAIL status_idle: got %h want %h", rd, prev); end
    @(posedge clk); #1;
    n_cmp++; if (uart_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL ready_one_cycle: got %b want 0", uart_ready); end
    n_cmp++; if (uart_rdata !== prev) begin n_bad++; $display("[TB] FAIL rdata_hold_idle: got %h want %h", uart_rdata, prev); end
    for (int i = 0; i < 3; i++) begin
      a = {2'(2 + i), 2'($urandom)};
      bus_access(1'b0, a, $urandom, rd, rdy, t);
      n_cmp++; if (rdy !== 1'b1 || rd !== 32'd0) begin
        n_bad++; $display("[TB] FAIL reserved_read: addr %h got rdy %b data %h want rdy 1 data 0", a, rdy, rd);
      end
    end
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    prev = model_status(t);
    bus_access(1'b1, {2'b10, 2'($urandom)}, $urandom, rd, rdy, t);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL ignored_write_ready: got %b want 1", rdy); end
    n_cmp++; if (rd !== prev) begin n_bad++; $display("[TB] FAIL rdata_hold_write: got %h want %h", rd, prev); end
    bus_access(1'b1, {2'b11, 2'($urandom)}, $urandom, rd, rdy, t);
    repeat (3 * C) begin @(posedge clk); #1; end
    n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("[TB] FAIL ignored_write_frames: got %0d want 0", rx_q.size()); end
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    prev = model_status(t);
    n_cmp++; if (rd !== prev) begin n_bad++; $display("[TB] FAIL status_after_ignored: got %h want %h", rd, prev); end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    logic [31:0] rd, ex;
    logic rdy, exp_bit;
    int t, s, d, err, first_bad;
    bit acc;
    rx_clear();
    bus_access(1'b1, {2'b00, 2'($urandom)}, {24'($urandom), b}, rd, rdy, t);
    acc = model_push(t);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL push_ready: got %b want 1", rdy); end
    s = start_q[start_q.size()-1];
    err = 0;
    first_bad = -99;
    while (cyc <= s + F + 3) begin
      d = cyc - s;
      exp_bit = (d >= 0 && d < F) ? frame_bit(b, d / C) : 1'b1;
      if (uart_tx !== exp_bit) begin
        err++;
        if (first_bad == -99) first_bad = d;
      end
      if (cyc == s + 5 * C) begin
        bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
        ex = model_status(t);
        n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL status_busy: got %h want %h", rd, ex); end
      end else begin
        @(posedge clk); #1;
      end
    end
    n_cmp++; if (err != 0) begin
      n_bad++; $display("[TB] FAIL frame_waveform: byte %h got %0d wrong cycles (first at offset %0d) want 0", b, err, first_bad);
    end
    n_cmp++; if (rx_q.size() != 1) begin
      n_bad++; $display("[TB] FAIL single_count: got %0d frames want 1", rx_q.size());
    end else begin
      n_cmp++; if (rx_q[0] !== b || rx_err_q[0] || rx_start_q[0] != s) begin
        n_bad++; $display("[TB] FAIL single_rx: got %h err %b start %0d want %h err 0 start %0d",
                          rx_q[0], rx_err_q[0], rx_start_q[0], b, s);
      end
    end
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL status_after_frame: got %h want %h", rd, ex); end
    if (!acc) $display("[TB] note: push of %h not accepted by model", b);
  endtask

  task automatic test_back_to_back(input int n, input bit use_hi);
    logic [31:0] rd, ex;
    logic rdy;
    logic [7:0] b;
    logic [7:0] exp_b[$];
    int exp_s[$];
    int t, base, deadline, span, cnt;
    rx_clear();
    base = start_q.size();
    for (int i = 0; i < n; i++) begin
      b = use_hi ? ((i == 0) ? 8'h48 : (i == 1) ? 8'h69 : 8'h0A) : 8'($urandom);
      bus_access(1'b1, 4'h0, {24'd0, b}, rd, rdy, t);
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_ready: got %b want 1", rdy); end
      if (model_push(t)) exp_b.push_back(b);
    end
    for (int k = base; k < start_q.size(); k++) exp_s.push_back(start_q[k]);
    deadline = cyc + exp_b.size() * F + 2 * F;
    while (rx_q.size() < exp_b.size() && cyc < deadline) begin @(posedge clk); #1; end
    cnt = rx_q.size();
    n_cmp++; if (cnt != exp_b.size()) begin
      n_bad++; $display("[TB] FAIL b2b_count: got %0d frames want %0d", cnt, exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < cnt; i++) begin
      n_cmp++; if (rx_q[i] !== exp_b[i] || rx_err_q[i] || rx_start_q[i] != exp_s[i]) begin
        n_bad++; $display("[TB] FAIL b2b_frame%0d: got %h err %b start %0d want %h err 0 start %0d",
                          i, rx_q[i], rx_err_q[i], rx_start_q[i], exp_b[i], exp_s[i]);
      end
    end
    if (cnt == exp_b.size() && cnt > 0) begin
      span = rx_start_q[cnt-1] + F - rx_start_q[0];
      n_cmp++; if (span != cnt * F) begin n_bad++; $display("[TB] FAIL b2b_span: got %0d cycles want %0d", span, cnt * F); end
    end
    repeat (2 * F) begin @(posedge clk); #1; end
    n_cmp++; if (rx_q.size() != cnt) begin n_bad++; $display("[TB] FAIL b2b_extra: got %0d frames want %0d", rx_q.size(), cnt); end
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL b2b_status_end: got %h want %h", rd, ex); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, ex;
    logic rdy;
    logic [7:0] b;
    logic [7:0] exp_b[$];
    int t, n, deadline;
    rx_clear();
    n = $urandom_range(9, 12);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      bus_access(1'b1, 4'h0, {24'($urandom), b}, rd, rdy, t);
      if (model_push(t)) exp_b.push_back(b);
    end
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL ovf_status: got %h want %h", rd, ex); end
    bus_access(1'b1, 4'h4, $urandom & ~32'h8, rd, rdy, t);
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL ovf_sticky: got %h want %h", rd, ex); end
    bus_access(1'b1, 4'h4, $urandom | 32'h8, rd, rdy, t);
    m_ovf = 1'b0;
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL ovf_clear: got %h want %h", rd, ex); end
    deadline = cyc + exp_b.size() * F + 2 * F;
    while (rx_q.size() < exp_b.size() && cyc < deadline) begin @(posedge clk); #1; end
    repeat (F) begin @(posedge clk); #1; end
    n_cmp++; if (rx_q.size() != exp_b.size()) begin
      n_bad++; $display("[TB] FAIL ovf_count: got %0d frames want %0d", rx_q.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_b[i] || rx_err_q[i]) begin
        n_bad++; $display("[TB] FAIL ovf_frame%0d: got %h err %b want %h err 0", i, rx_q[i], rx_err_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_full_pop_collision();
    logic [31:0] rd, ex;
    logic rdy;
    logic [7:0] b;
    logic [7:0] exp_b[$];
    int t, s, base, deadline;
    rx_clear();
    base = start_q.size();
    for (int i = 0; i <= D; i++) begin
      b = 8'($urandom);
      bus_access(1'b1, 4'h0, {24'd0, b}, rd, rdy, t);
      if (model_push(t)) exp_b.push_back(b);
    end
    s = start_q[base];
    while (cyc < s + F - 1) begin @(posedge clk); #1; end
    b = 8'($urandom);
    bus_access(1'b1, 4'h0, {24'd0, b}, rd, rdy, t);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL collide_ready: got %b want 1", rdy); end
    if (model_push(t)) exp_b.push_back(b);
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL collide_status: got %h want %h", rd, ex); end
    b = 8'($urandom);
    bus_access(1'b1, 4'h0, {24'd0, b}, rd, rdy, t);
    if (model_push(t)) exp_b.push_back(b);
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL refill_status: got %h want %h", rd, ex); end
    deadline = cyc + exp_b.size() * F + 2 * F;
    while (rx_q.size() < exp_b.size() && cyc < deadline) begin @(posedge clk); #1; end
    repeat (F) begin @(posedge clk); #1; end
    n_cmp++; if (rx_q.size() != exp_b.size()) begin
      n_bad++; $display("[TB] FAIL collide_count: got %0d frames want %0d", rx_q.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_b[i] || rx_err_q[i] || rx_start_q[i] != start_q[base+i]) begin
        n_bad++; $display("[TB] FAIL collide_frame%0d: got %h start %0d want %h start %0d",
                          i, rx_q[i], rx_start_q[i], exp_b[i], start_q[base+i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd, ex;
    logic rdy;
    logic [7:0] b;
    int t, s, lows;
    bit acc;
    rx_clear();
    b = 8'($urandom) & 8'hF7;
    bus_access(1'b1, 4'h0, {24'd0, b}, rd, rdy, t);
    acc = model_push(t);
    s = start_q[start_q.size()-1];
    for (int i = 0; i < 2; i++) begin
      bus_access(1'b1, 4'h0, $urandom, rd, rdy, t);
      acc = model_push(t);
    end
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL pre_reset_status: got %h want %h", rd, ex); end
    while (cyc < s + 4 * C + 5) begin @(posedge clk); #1; end
    n_cmp++; if (uart_tx !== frame_bit(b, 4)) begin n_bad++; $display("[TB] FAIL pre_reset_bit3: got %b want %b", uart_tx, frame_bit(b, 4)); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_async_tx: got %b want 1", uart_tx); end
    n_cmp++; if (uart_rdata !== 32'd0 || uart_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_async_bus: got rdata %h ready %b want 0 0", uart_rdata, uart_ready);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rx_clear();
    bus_access(1'b0, 4'h4, 32'd0, rd, rdy, t);
    ex = model_status(t);
    n_cmp++; if (rd !== ex) begin n_bad++; $display("[TB] FAIL post_abort_status: got %h want %h", rd, ex); end
    lows = 0;
    repeat (3 * F) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0 || rx_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL post_abort_line: got %0d low cycles %0d frames want 0 0", lows, rx_q.size());
    end
    if (!acc) $display("[TB] note: pending push not accepted by model");
  endtask

  initial begin
    test_reset();
    test_status_idle();
    test_single_frame(8'h55);
    repeat (3) test_single_frame(8'($urandom));
    test_back_to_back(3, 1'b1);
    repeat (2) test_back_to_back($urandom_range(2, 5), 1'b0);
    test_overflow();
    test_full_pop_collision();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Memory-mapped UART transmitter for the riscv_soc peripheral slot on simple_bus. It drives the SoC `uart_tx` pin and is the transmitting end of the 8N1 link that the testbench UART monitor receives (115200 baud at 50 MHz).
- CPU stores bytes into a small TX FIFO.
- A baud-timed serializer drains the FIFO: 1 start bit, 8 data bits LSB first, 1 stop bit, line idle high.
- A status register exposes busy, full, empty and a sticky overflow flag.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200). Minimum 4.
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- uart_req  input  1  bus access strobe for this slave (single cycle).
- uart_we  input  1  1 = write, 0 = read.
- uart_addr  input  4  byte offset within the block; bits [1:0] ignored.
- uart_wdata  input  32  write data.
- uart_rdata  output  32  read data, registered.
- uart_ready  output  1  access complete, registered.
- uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset (async assert, sync deassert by the environment) drives outputs immediately:
  - uart_tx=1, uart_ready=0, uart_rdata=0.
  - FIFO emptied; overflow=0; FSM=IDLE; baud and bit counters=0.
- Register map:
  - 0x0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 0x4 STATUS: read returns {28'b0, overflow, empty, full, busy}. Write with wdata[3]=1 clears overflow; other bits read-only.
  - 0x8 and 0xC: reads return 0, writes ignored.
- Bus timing:
  - uart_ready pulses for exactly one cycle, on the edge after any cycle with uart_req=1 (one-cycle latency for every access, including dropped writes).
  - uart_rdata is valid in the same cycle as uart_ready and holds until the next read.
- FIFO:
  - Push accepted when uart_req & uart_we & addr==0x0 & !full.
  - Push while full: byte dropped, overflow set (sticky).
  - The full check uses the pre-edge count, so a pop in the same cycle does not rescue a push to a full FIFO.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- busy = (FSM != IDLE).
- FSM states IDLE, START, DATA, STOP. bit_idx counts 0..7; baud_cnt counts 0..CLKS_PER_BIT-1.
  - IDLE: uart_tx=1. If FIFO non-empty: pop into shift register, baud_cnt=0, go to START. A push accepted at edge N makes uart_tx fall at edge N+1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit_idx 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- uart_tx is registered (driven from a flop); no combinational path from bus inputs to uart_tx.
- Frame length is exactly 10*CLKS_PER_BIT cycles, start-bit falling edge to the end of the stop bit.
- A push that coincides with the IDLE pop of the only FIFO entry is accepted normally (count unchanged that edge).
- Reset mid-frame aborts the frame: uart_tx returns high asynchronously and all pending bytes are discarded.

Test Plan:
- CLKS_PER_BIT=16: write 0x55 to 0x0 at edge N → uart_tx low at N+1 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles. busy=1 throughout, 0 afterwards.
- Write 0x48, 0x69, 0x0A back-to-back → three frames totalling exactly 480 cycles (CLKS_PER_BIT=16) with no idle gap. A 434-clock monitor receiver at default parameters prints "Hi\n".
- FIFO_DEPTH=8: write 10 bytes while the first frame is in progress → the first byte is popped into the serializer, 8 bytes fill the FIFO, the 10th is dropped. STATUS reads 0xB (overflow, full, busy). Write 0x8 to 0x4 → overflow clears; other bits unchanged.
- Reads of STATUS when idle and empty → 0x4, with uart_ready high exactly one cycle after uart_req. Read of 0x8 → 0.
- Assert rst_n=0 in the middle of DATA bit 3 → uart_tx=1 in the same cycle. After release, STATUS=0x4 and no further frames are emitted.
- Push to a full FIFO on the same edge as a STOP-final pop → push dropped, overflow set, count decrements to FIFO_DEPTH-1.
